eim_dot_accumulator: RTL and testbench

//  Downstream stage of the 8x8 approximate (EIM) multiplier in a processing element.

---
 rtl/eim_dot_accumulator.sv | 107 ++++++++++
 tb/tb_eim_dot_accumulator.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eim_dot_accumulator.sv
// Dot-product accumulator behind the EIM approximate multiplier.
// Sums len products per result and hands the sum out over valid/ready.
module eim_dot_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [LEN_W-1:0]  len,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    state_t state, state_nx;

    logic [ACC_W-1:0] acc, acc_nx;
    logic             ovf, ovf_nx;
    logic [LEN_W-1:0] cnt, cnt_nx;
    logic [LEN_W-1:0] len_q, len_nx;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] cnt_inc;
    logic [ACC_W:0]   sum;
    logic             beat;

    assign prod_ready = (state != HOLD);
    assign beat       = prod_valid && prod_ready;
    assign len_eff    = (len == '0) ? LEN_W'(1) : len;
    assign cnt_inc    = cnt + LEN_W'(1);
    // Extra top bit of the sum is the carry-out feeding the sticky flag
    assign sum        = {1'b0, acc} + {1'b0, ACC_W'(prod_data)};

    assign out_valid  = (state == HOLD);
    assign out_data   = acc;
    assign out_ovf    = ovf;

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        ovf_nx   = ovf;
        cnt_nx   = cnt;
        len_nx   = len_q;
        unique case (state)
            IDLE: begin
                if (beat) begin
                    len_nx   = len_eff;
                    acc_nx   = ACC_W'(prod_data);
                    cnt_nx   = LEN_W'(1);
                    ovf_nx   = 1'b0;
                    state_nx = (len_eff == LEN_W'(1)) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (beat) begin
                    acc_nx = sum[ACC_W-1:0];
                    ovf_nx = ovf | sum[ACC_W];
                    cnt_nx = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_nx = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Abort wins over any beat or output handshake in the same cycle
        if (clear) begin
            state_nx = IDLE;
            acc_nx   = '0;
            ovf_nx   = 1'b0;
            cnt_nx   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            ovf   <= ovf_nx;
            cnt   <= cnt_nx;
            len_q <= len_nx;
        end
    end

endmodule

// File: tb/tb_eim_dot_accumulator.sv
// Bench for eim_dot_accumulator: 32-bit and 16-bit accumulators in lockstep
// against a sum-of-beats reference, plus directed literal scenarios.
module tb_eim_dot_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  len = 8'd1;
    logic        prod_valid = 1'b0;
    logic [15:0] prod_data = 16'd0;
    logic        out_ready = 1'b1;

    logic        ready32, valid32, ovf32;
    logic [31:0] data32;
    logic        ready16, valid16, ovf16;
    logic [15:0] data16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eim_dot_accumulator #(.PROD_W(16), .ACC_W(32), .LEN_W(8)) u32 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .len(len),
        .prod_valid(prod_valid), .prod_ready(ready32), .prod_data(prod_data),
        .out_valid(valid32), .out_ready(out_ready),
        .out_data(data32), .out_ovf(ovf32)
    );

    eim_dot_accumulator #(.PROD_W(16), .ACC_W(16), .LEN_W(8)) u16 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .len(len),
        .prod_valid(prod_valid), .prod_ready(ready16), .prod_data(prod_data),
        .out_valid(valid16), .out_ready(out_ready),
        .out_data(data16), .out_ovf(ovf16)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a result is the plain sum of its accepted beats
    logic [63:0] m_sum = 64'd0;
    int          m_cnt = 0;
    int          m_len = 1;
    bit          m_hold = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_sum  = 64'd0;
            m_cnt  = 0;
            m_hold = 1'b0;
            chk("rst_valid32", valid32, 0);
            chk("rst_data32", data32, 0);
            chk("rst_ovf32", ovf32, 0);
            chk("rst_ready32", ready32, 1);
            chk("rst_valid16", valid16, 0);
            chk("rst_data16", data16, 0);
        end else begin
            chk("ready32", ready32, !m_hold);
            chk("ready16", ready16, !m_hold);
            chk("valid32", valid32, m_hold);
            chk("valid16", valid16, m_hold);
            if (m_hold) begin
                chk("data32", data32, m_sum[31:0]);
                chk("ovf32", ovf32, m_sum >= 64'h1_0000_0000);
                chk("data16", data16, m_sum[15:0]);
                chk("ovf16", ovf16, m_sum >= 64'h1_0000);
            end
            if (clear) begin
                m_sum  = 64'd0;
                m_cnt  = 0;
                m_hold = 1'b0;
            end else if (m_hold) begin
                if (out_ready) begin
                    m_hold = 1'b0;
                    m_cnt  = 0;
                    m_sum  = 64'd0;
                end
            end else if (prod_valid) begin
                if (m_cnt == 0) m_len = (len == 8'd0) ? 1 : int'(len);
                m_sum = m_sum + 64'(prod_data);
                m_cnt++;
                if (m_cnt == m_len) m_hold = 1'b1;
            end
        end
    end

    // Enter and leave at posedge+1
    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        prod_valid = 1'b1;
        prod_data  = d;
        @(negedge clk);
        while (!ready32 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", n < 50, 1);
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // T1: back-to-back, result one cycle after last beat
        len = 8'd4;
        out_ready = 1'b1;
        send(16'd10); send(16'd20); send(16'd30); send(16'd40);
        @(negedge clk);
        chk("t1_valid", valid32, 1);
        chk("t1_data", data32, 100);
        chk("t1_ovf", ovf32, 0);
        next_cycle();
        @(negedge clk);
        chk("t1_idle", valid32, 0);
        next_cycle();

        // T2: gaps between beats and a stalled consumer
        len = 8'd3;
        out_ready = 1'b0;
        send(16'd5);
        repeat (2) @(posedge clk);
        #1;
        send(16'd7);
        repeat (2) @(posedge clk);
        #1;
        send(16'd9);
        prod_valid = 1'b1;
        prod_data  = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", valid32, 1);
            chk("t2_hold_data", data32, 21);
            chk("t2_hold_ready", ready32, 0);
            next_cycle();
        end
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("t2_released", valid32, 0);
        chk("t2_ready", ready32, 1);
        next_cycle();

        // T3: len 0 behaves as len 1
        len = 8'd0;
        send(16'hFFFF);
        @(negedge clk);
        chk("t3_valid", valid32, 1);
        chk("t3_data", data32, 32'h0000FFFF);
        next_cycle();

        // T4: 16-bit wrap sets the sticky flag, next result clears it
        len = 8'd2;
        send(16'hFFFF); send(16'h0002);
        @(negedge clk);
        chk("t4_data16", data16, 16'h0001);
        chk("t4_ovf16", ovf16, 1);
        chk("t4_data32", data32, 32'h0001_0001);
        chk("t4_ovf32", ovf32, 0);
        next_cycle();
        len = 8'd1;
        send(16'd3);
        @(negedge clk);
        chk("t4b_data16", data16, 3);
        chk("t4b_ovf16", ovf16, 0);
        next_cycle();

        // T5: clear drops a coincident beat
        len = 8'd4;
        send(16'd11); send(16'd12);
        prod_valid = 1'b1;
        prod_data  = 16'd50;
        clear      = 1'b1;
        next_cycle();
        clear      = 1'b0;
        prod_valid = 1'b0;
        @(negedge clk);
        chk("t5_valid", valid32, 0);
        chk("t5_acc", data32, 0);
        chk("t5_ready", ready32, 1);
        next_cycle();
        len = 8'd2;
        send(16'd1); send(16'd2);
        @(negedge clk);
        chk("t5_data", data32, 3);
        next_cycle();

        // T6: async reset in ACC and in HOLD
        len = 8'd4;
        send(16'd7); send(16'd8);
        #1 rst_n = 1'b0;
        #1;
        chk("t6a_valid", valid32, 0);
        chk("t6a_data", data32, 0);
        next_cycle();
        rst_n = 1'b1;
        len = 8'd2;
        out_ready = 1'b0;
        send(16'd4); send(16'd6);
        @(negedge clk);
        chk("t6b_pre_data", data32, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("t6b_valid", valid32, 0);
        chk("t6b_data", data32, 0);
        chk("t6b_ovf", ovf32, 0);
        @(negedge clk);
        next_cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        len = 8'd1;
        send(16'd9);
        @(negedge clk);
        chk("t6_resume", data32, 9);
        next_cycle();

        // T7: maximum count of full-scale products
        len = 8'hFF;
        for (int i = 0; i < 255; i++) send(16'hFFFF);
        @(negedge clk);
        chk("t7_data32", data32, 32'h00FE_FF01);
        chk("t7_ovf32", ovf32, 0);
        chk("t7_data16", data16, 16'hFF01);
        chk("t7_ovf16", ovf16, 1);
        next_cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            prod_valid = ($urandom_range(0, 9) < 7);
            prod_data  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            len        = 8'($urandom_range(0, 6));
            out_ready  = ($urandom_range(0, 9) < 6);
            clear      = ($urandom_range(0, 49) == 0);
            next_cycle();
        end
        prod_valid = 1'b0;
        clear      = 1'b0;
        out_ready  = 1'b1;
        repeat (10) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
